// File: rtl/rf_wrport_arb_if.sv
// Bundles the M-stage pipeline write, late write request, S-stage hazard probe and rf write port C.
// The master drives requests and read addresses, and the slave (arbiter) drives ack, hazard, stall and port C.
interface rf_wrport_arb_if;
    logic        CLMI_RHOLD;
    logic        CP0_XCPN_M_C1;
    logic        PIPE_WR_M;
    logic [4:0]  PIPE_ADDR_M;
    logic [31:0] PIPE_DATA_M;
    logic        LATE_REQ;
    logic [4:0]  LATE_ADDR;
    logic [31:0] LATE_DATA;
    logic        LATE_ACK;
    logic [4:0]  REGAADDR_S;
    logic [4:0]  REGBADDR_S;
    logic        HAZA_S;
    logic        HAZB_S;
    logic        REGCWRITE_W_R;
    logic [4:0]  REGCADDR_W_R;
    logic [31:0] REGCDATA_W_R;
    logic        STALL_REQ;

    modport master (
        output CLMI_RHOLD, CP0_XCPN_M_C1, PIPE_WR_M, PIPE_ADDR_M, PIPE_DATA_M,
        output LATE_REQ, LATE_ADDR, LATE_DATA, REGAADDR_S, REGBADDR_S,
        input  LATE_ACK, HAZA_S, HAZB_S, REGCWRITE_W_R, REGCADDR_W_R, REGCDATA_W_R, STALL_REQ
    );

    modport slave (
        input  CLMI_RHOLD, CP0_XCPN_M_C1, PIPE_WR_M, PIPE_ADDR_M, PIPE_DATA_M,
        input  LATE_REQ, LATE_ADDR, LATE_DATA, REGAADDR_S, REGBADDR_S,
        output LATE_ACK, HAZA_S, HAZB_S, REGCWRITE_W_R, REGCADDR_W_R, REGCDATA_W_R, STALL_REQ
    );
endinterface

// File: rtl/rf_wrport_arb.sv
// Arbitrates rf write port C between pipeline writes (1 cycle to port) and a 2-deep late-write buffer (2 cycles).
// Late requests wait un-acked while the buffer is full, and STALL_REQ tells the pipeline to hold until it drains.
module rf_wrport_arb (
    input  logic           SYSCLK,
    input  logic           RESET_D1_R,
    rf_wrport_arb_if.slave rf
);

    typedef struct packed {
        logic        vld;
        logic [4:0]  addr;
        logic [31:0] dat;
    } wr_ent_t;

    wr_ent_t     ent0_q, ent1_q;
    wr_ent_t     ent0_nxt, ent1_nxt, late_ent;
    logic        pipe_acc, deq, full, late_ack, late_drop, enq;
    logic        keep0, keep1;
    logic        wr_q;
    logic [4:0]  addr_q;
    logic [31:0] dat_q;
    logic        stall_q;

    always_comb begin
        pipe_acc  = rf.PIPE_WR_M & ~rf.CLMI_RHOLD & ~rf.CP0_XCPN_M_C1 & (rf.PIPE_ADDR_M != 5'd0);
        deq       = ~pipe_acc & ent0_q.vld;
        full      = ent0_q.vld & ent1_q.vld;
        late_ack  = rf.LATE_REQ & ~RESET_D1_R & (~full | deq);
        // Writes to r0 and writes already overtaken by the same-cycle pipeline write are useless.
        late_drop = (rf.LATE_ADDR == 5'd0) | (pipe_acc & (rf.LATE_ADDR == rf.PIPE_ADDR_M));
        enq       = late_ack & ~late_drop;
        late_ent  = '{vld: 1'b1, addr: rf.LATE_ADDR, dat: rf.LATE_DATA};

        // An entry survives unless it is dequeued now or squashed by a younger pipeline write.
        keep0 = ent0_q.vld & ~deq & ~(pipe_acc & (ent0_q.addr == rf.PIPE_ADDR_M));
        keep1 = ent1_q.vld & ~(pipe_acc & (ent1_q.addr == rf.PIPE_ADDR_M));

        ent0_nxt = '0;
        ent1_nxt = '0;
        case ({keep0, keep1})
            2'b11: begin
                ent0_nxt = ent0_q;
                ent1_nxt = ent1_q;
            end
            2'b10: begin
                ent0_nxt = ent0_q;
                if (enq) ent1_nxt = late_ent;
            end
            2'b01: begin
                ent0_nxt = ent1_q;
                if (enq) ent1_nxt = late_ent;
            end
            default: begin
                if (enq) ent0_nxt = late_ent;
            end
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET_D1_R) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= 5'd0;
            dat_q   <= 32'd0;
            stall_q <= 1'b0;
        end else begin
            ent0_q  <= ent0_nxt;
            ent1_q  <= ent1_nxt;
            stall_q <= ent0_nxt.vld & ent1_nxt.vld;
            if (pipe_acc) begin
                wr_q   <= 1'b1;
                addr_q <= rf.PIPE_ADDR_M;
                dat_q  <= rf.PIPE_DATA_M;
            end else if (deq) begin
                wr_q   <= 1'b1;
                addr_q <= ent0_q.addr;
                dat_q  <= ent0_q.dat;
            end else begin
                wr_q   <= 1'b0;
            end
        end
    end

    // A pending late write shadows the rf copy until it reaches port C.
    assign rf.HAZA_S = ~RESET_D1_R & (rf.REGAADDR_S != 5'd0) &
                       ((ent0_q.vld & (ent0_q.addr == rf.REGAADDR_S)) |
                        (ent1_q.vld & (ent1_q.addr == rf.REGAADDR_S)) |
                        (enq & (rf.LATE_ADDR == rf.REGAADDR_S)));
    assign rf.HAZB_S = ~RESET_D1_R & (rf.REGBADDR_S != 5'd0) &
                       ((ent0_q.vld & (ent0_q.addr == rf.REGBADDR_S)) |
                        (ent1_q.vld & (ent1_q.addr == rf.REGBADDR_S)) |
                        (enq & (rf.LATE_ADDR == rf.REGBADDR_S)));

    assign rf.LATE_ACK      = late_ack;
    assign rf.REGCWRITE_W_R = wr_q;
    assign rf.REGCADDR_W_R  = addr_q;
    assign rf.REGCDATA_W_R  = dat_q;
    assign rf.STALL_REQ     = stall_q;

endmodule

// File: tb/tb_rf_wrport_arb.sv
// Directed bench for rf_wrport_arb: inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
module tb_rf_wrport_arb;

    logic SYSCLK;
    logic RESET_D1_R;
    int   n_run;
    int   n_fail;

    rf_wrport_arb_if rf ();

    rf_wrport_arb dut (
        .SYSCLK     (SYSCLK),
        .RESET_D1_R (RESET_D1_R),
        .rf         (rf.slave)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic smp();
        @(negedge SYSCLK);
    endtask

    task automatic idle();
        rf.CLMI_RHOLD    = 1'b0;
        rf.CP0_XCPN_M_C1 = 1'b0;
        rf.PIPE_WR_M     = 1'b0;
        rf.PIPE_ADDR_M   = 5'd0;
        rf.PIPE_DATA_M   = 32'd0;
        rf.LATE_REQ      = 1'b0;
        rf.LATE_ADDR     = 5'd0;
        rf.LATE_DATA     = 32'd0;
        rf.REGAADDR_S    = 5'd0;
        rf.REGBADDR_S    = 5'd0;
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        rf.PIPE_WR_M   = 1'b1;
        rf.PIPE_ADDR_M = a;
        rf.PIPE_DATA_M = d;
    endtask

    task automatic late(input logic [4:0] a, input logic [31:0] d);
        rf.LATE_REQ  = 1'b1;
        rf.LATE_ADDR = a;
        rf.LATE_DATA = d;
    endtask

    task automatic chk_port(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_wr"}, 32'(rf.REGCWRITE_W_R), 32'(w));
        chk({tag, "_addr"}, 32'(rf.REGCADDR_W_R), 32'(a));
        chk({tag, "_dat"}, rf.REGCDATA_W_R, d);
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        RESET_D1_R = 1'b1;
        idle();
        tick();

        // Reset: outputs cleared and a late request is ignored
        late(5'd4, 32'h44);
        rf.REGAADDR_S = 5'd4;
        smp();
        chk_port("rst", 1'b0, 5'd0, 32'd0);
        chk("rst_stall", 32'(rf.STALL_REQ), 32'd0);
        chk("rst_ack", 32'(rf.LATE_ACK), 32'd0);
        chk("rst_haza", 32'(rf.HAZA_S), 32'd0);
        tick();
        RESET_D1_R = 1'b0;
        idle();
        tick();

        // Plain pipeline write, then idle holds addr/data
        pipe(5'd5, 32'h1234);
        tick();
        idle();
        smp();
        chk_port("pipe5", 1'b1, 5'd5, 32'h1234);
        tick();
        smp();
        chk_port("pipe5_idle", 1'b0, 5'd5, 32'h1234);

        // Killed, r0 and held pipeline writes never reach the port
        tick();
        pipe(5'd6, 32'h66);
        rf.CP0_XCPN_M_C1 = 1'b1;
        tick();
        idle();
        smp();
        chk_port("xcpn", 1'b0, 5'd5, 32'h1234);
        tick();
        pipe(5'd0, 32'h77);
        tick();
        idle();
        smp();
        chk("r0_wr", 32'(rf.REGCWRITE_W_R), 32'd0);
        tick();
        pipe(5'd6, 32'h88);
        rf.CLMI_RHOLD = 1'b1;
        tick();
        idle();
        smp();
        chk("rhold_wr", 32'(rf.REGCWRITE_W_R), 32'd0);
        tick();

        // Late write 7 behind a 3-cycle pipeline stream to 3
        pipe(5'd3, 32'h33);
        late(5'd7, 32'hAA);
        rf.REGAADDR_S = 5'd7;
        smp();
        chk("l7_ack", 32'(rf.LATE_ACK), 32'd1);
        chk("l7_haza_c0", 32'(rf.HAZA_S), 32'd1);
        tick();
        rf.LATE_REQ = 1'b0;
        smp();
        chk_port("l7_c1", 1'b1, 5'd3, 32'h33);
        chk("l7_haza_c1", 32'(rf.HAZA_S), 32'd1);
        tick();
        tick();
        rf.PIPE_WR_M = 1'b0;
        smp();
        chk_port("l7_c3", 1'b1, 5'd3, 32'h33);
        tick();
        smp();
        chk_port("l7_c4", 1'b1, 5'd7, 32'hAA);
        chk("l7_haza_c4", 32'(rf.HAZA_S), 32'd0);
        idle();
        tick();

        // Late into empty buffer with no competition: port two cycles later
        late(5'd11, 32'hBB);
        rf.REGBADDR_S = 5'd11;
        smp();
        chk("l11_ack", 32'(rf.LATE_ACK), 32'd1);
        chk("l11_hazb", 32'(rf.HAZB_S), 32'd1);
        tick();
        idle();
        smp();
        chk("l11_c1_wr", 32'(rf.REGCWRITE_W_R), 32'd0);
        tick();
        smp();
        chk_port("l11_c2", 1'b1, 5'd11, 32'hBB);
        tick();

        // Late write to r0 is acked and dropped
        late(5'd0, 32'hCC);
        smp();
        chk("l0_ack", 32'(rf.LATE_ACK), 32'd1);
        chk("l0_haza", 32'(rf.HAZA_S), 32'd0);
        tick();
        idle();
        tick();
        smp();
        chk("l0_c2_wr", 32'(rf.REGCWRITE_W_R), 32'd0);
        tick();

        // Fill the buffer (8,9), 10 is refused until the hold lets it drain
        pipe(5'd3, 32'h30);
        late(5'd8, 32'h80);
        smp();
        chk("l8_ack", 32'(rf.LATE_ACK), 32'd1);
        tick();
        late(5'd9, 32'h90);
        smp();
        chk("l9_ack", 32'(rf.LATE_ACK), 32'd1);
        chk("l9_stall", 32'(rf.STALL_REQ), 32'd0);
        tick();
        late(5'd10, 32'hA0);
        smp();
        chk("l10_noack", 32'(rf.LATE_ACK), 32'd0);
        chk("full_stall", 32'(rf.STALL_REQ), 32'd1);
        tick();
        rf.CLMI_RHOLD = 1'b1;
        smp();
        chk("l10_ack", 32'(rf.LATE_ACK), 32'd1);
        chk_port("hold_c3", 1'b1, 5'd3, 32'h30);
        tick();
        rf.LATE_REQ = 1'b0;
        smp();
        chk_port("drain8", 1'b1, 5'd8, 32'h80);
        chk("drain8_stall", 32'(rf.STALL_REQ), 32'd1);
        tick();
        smp();
        chk_port("drain9", 1'b1, 5'd9, 32'h90);
        chk("drain9_stall", 32'(rf.STALL_REQ), 32'd0);
        tick();
        idle();
        smp();
        chk_port("drain10", 1'b1, 5'd10, 32'hA0);
        tick();
        smp();
        chk("drained_wr", 32'(rf.REGCWRITE_W_R), 32'd0);
        tick();

        // Buffered 12 is squashed by a younger pipeline write to 12
        pipe(5'd3, 32'h31);
        late(5'd12, 32'hC12);
        tick();
        idle();
        pipe(5'd12, 32'h1200);
        rf.REGAADDR_S = 5'd12;
        smp();
        chk("sq_haza_pre", 32'(rf.HAZA_S), 32'd1);
        tick();
        idle();
        rf.REGAADDR_S = 5'd12;
        smp();
        chk_port("sq_pipe", 1'b1, 5'd12, 32'h1200);
        chk("sq_haza_post", 32'(rf.HAZA_S), 32'd0);
        tick();
        smp();
        chk("sq_nowr", 32'(rf.REGCWRITE_W_R), 32'd0);
        tick();

        // Same-cycle late and pipeline write to 14: late one dropped
        pipe(5'd14, 32'h1);
        late(5'd14, 32'h2);
        rf.REGBADDR_S = 5'd14;
        smp();
        chk("same_ack", 32'(rf.LATE_ACK), 32'd1);
        chk("same_hazb", 32'(rf.HAZB_S), 32'd0);
        tick();
        idle();
        smp();
        chk_port("same_pipe", 1'b1, 5'd14, 32'h1);
        tick();
        smp();
        chk("same_nowr", 32'(rf.REGCWRITE_W_R), 32'd0);
        tick();

        // Reset pulse with a full buffer discards everything
        pipe(5'd3, 32'h32);
        late(5'd20, 32'h20);
        tick();
        late(5'd21, 32'h21);
        tick();
        idle();
        smp();
        chk("pre_rst_stall", 32'(rf.STALL_REQ), 32'd1);
        tick();
        RESET_D1_R = 1'b1;
        late(5'd22, 32'h22);
        rf.REGAADDR_S = 5'd20;
        smp();
        chk("inrst_ack", 32'(rf.LATE_ACK), 32'd0);
        chk("inrst_haza", 32'(rf.HAZA_S), 32'd0);
        tick();
        RESET_D1_R = 1'b0;
        idle();
        rf.REGAADDR_S = 5'd20;
        smp();
        chk_port("post_rst", 1'b0, 5'd0, 32'd0);
        chk("post_rst_stall", 32'(rf.STALL_REQ), 32'd0);
        chk("post_rst_haza", 32'(rf.HAZA_S), 32'd0);
        tick();
        smp();
        chk("post_rst_c1_wr", 32'(rf.REGCWRITE_W_R), 32'd0);
        tick();
        smp();
        chk("post_rst_c2_wr", 32'(rf.REGCWRITE_W_R), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
